io_out_queue: RTL and testbench

- Output-IO stage directly downstream of the fixed-point processor core.
- Captures each core OUT write (out_en, addr_out, data_out) into a small FIFO.
- Presents queued writes one at a time to peripherals over a valid/ready handshake.
- The core cannot stall, so writes that arrive when the queue is full are dropped and flagged.

---
 rtl/io_out_pkg.sv | 18 +
 rtl/io_out_queue_fifo_ram.sv | 24 ++
 rtl/io_out_queue.sv | 122 ++++++++++++
 tb/tb_io_out_queue.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_out_pkg.sv
// Shared widths and the write-entry record for the output-IO queue.
// io_wr_t is sized from these defaults; the top's parameters must match them.
package io_out_pkg;

  localparam int unsigned IO_NUBITS = 32;
  localparam int unsigned IO_NUIOOU = 8;
  localparam int unsigned IO_FDEPTH = 4;

  localparam int unsigned IO_AW = $clog2(IO_NUIOOU);
  localparam int unsigned IO_PW = $clog2(IO_FDEPTH) + 1;
  localparam int unsigned IO_LW = $clog2(IO_FDEPTH + 1) + 1;

  typedef struct packed {
    logic [IO_AW-1:0]     addr;
    logic [IO_NUBITS-1:0] data;
  } io_wr_t;

endpackage

// File: rtl/io_out_queue_fifo_ram.sv
// FDEPTH x io_wr_t register array: one synchronous write port and one
// combinational read port, both addressed by pointer index.
module fifo_ram
  import io_out_pkg::*;
#(
  parameter int unsigned FDEPTH = IO_FDEPTH
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [$clog2(FDEPTH)-1:0] waddr,
  input  io_wr_t                    wdata,
  input  logic [$clog2(FDEPTH)-1:0] raddr,
  output io_wr_t                    rdata
);

  io_wr_t mem [FDEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/io_out_queue.sv
// Output-IO queue: buffers core OUT writes and hands them to peripherals over
// valid/ready. Optional per-address shadow bus under IO_OUT_SHADOW_EN.
module io_out_queue
  import io_out_pkg::*;
#(
  parameter int unsigned NUBITS = IO_NUBITS,
  parameter int unsigned NUIOOU = IO_NUIOOU,
  parameter int unsigned FDEPTH = IO_FDEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           out_en,
  input  logic [$clog2(NUIOOU)-1:0]      addr_out,
  input  logic [NUBITS-1:0]              data_out,
  output logic                           port_valid,
  output logic [$clog2(NUIOOU)-1:0]      port_addr,
  output logic [NUBITS-1:0]              port_data,
  input  logic                           port_ready,
  output logic [$clog2(FDEPTH+1):0]      level,
  output logic                           ovf,
  input  logic                           ovf_clr
`ifdef IO_OUT_SHADOW_EN
  ,
  output logic [NUIOOU*NUBITS-1:0]       shadow
`endif
);

  localparam int unsigned AW = $clog2(NUIOOU);
  localparam int unsigned IW = $clog2(FDEPTH);
  localparam int unsigned PW = IW + 1;
  localparam int unsigned LW = $clog2(FDEPTH + 1) + 1;

  logic [PW-1:0] rd_ptr, wr_ptr;
  io_wr_t        out_q;
  io_wr_t        wr_entry;
  io_wr_t        fifo_head;

  logic fifo_empty;
  logic q_full;
  logic pop;
  logic accept;
  logic bypass;
  logic fifo_wr;

  assign wr_entry = '{addr: addr_out, data: data_out};

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign q_full     = (level == LW'(FDEPTH + 1));
  assign pop        = port_valid & port_ready;
  assign accept     = out_en & (~q_full | pop);
  // Bypass only when nothing is queued ahead, so FIFO order is never skipped.
  assign bypass     = accept & fifo_empty & (~port_valid | pop);
  assign fifo_wr    = accept & ~bypass;

  fifo_ram #(
    .FDEPTH (FDEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (fifo_wr),
    .waddr (wr_ptr[IW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[IW-1:0]),
    .rdata (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      out_q      <= '0;
      port_valid <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        if (!fifo_empty) begin
          out_q      <= fifo_head;
          rd_ptr     <= rd_ptr + 1'b1;
          port_valid <= 1'b1;
        end else if (bypass) begin
          out_q      <= wr_entry;
          port_valid <= 1'b1;
        end else begin
          port_valid <= 1'b0;
        end
      end else if (bypass) begin
        out_q      <= wr_entry;
        port_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      level <= '0;
      ovf   <= 1'b0;
    end else begin
      case ({accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (out_en && !accept) ovf <= 1'b1;
      else if (ovf_clr)      ovf <= 1'b0;
    end
  end

  assign port_addr = out_q.addr;
  assign port_data = out_q.data;

`ifdef IO_OUT_SHADOW_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow <= '0;
    end else if (pop) begin
      for (int unsigned a = 0; a < NUIOOU; a++) begin
        if (port_addr == AW'(a)) shadow[a*NUBITS +: NUBITS] <= port_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_io_out_queue.sv
// Directed self-checking bench for io_out_queue (default parameters).
module tb_io_out_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_en;
  logic [2:0]  addr_out;
  logic [31:0] data_out;
  logic        port_valid;
  logic [2:0]  port_addr;
  logic [31:0] port_data;
  logic        port_ready;
  logic [3:0]  level;
  logic        ovf;
  logic        ovf_clr;
`ifdef IO_OUT_SHADOW_EN
  logic [255:0] shadow;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_out_queue #(
    .NUBITS (32),
    .NUIOOU (8),
    .FDEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .out_en     (out_en),
    .addr_out   (addr_out),
    .data_out   (data_out),
    .port_valid (port_valid),
    .port_addr  (port_addr),
    .port_data  (port_data),
    .port_ready (port_ready),
    .level      (level),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
`ifdef IO_OUT_SHADOW_EN
    ,
    .shadow     (shadow)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; out_en = 1'b0; ovf_clr = 1'b0; port_ready = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; out_en = 1'b1; addr_out = 3'd5; data_out = 32'd77;
    port_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    checks++;
    if (port_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", port_valid); end
    checks++;
    if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++;
    if (port_addr !== 3'd0 || port_data !== 32'd0) begin
      errors++; $display("FAIL reset_head got %0d/%h want 0/0", port_addr, port_data);
    end
`ifdef IO_OUT_SHADOW_EN
    checks++;
    if (shadow !== '0) begin errors++; $display("FAIL reset_shadow got %h want 0", shadow); end
`endif
    rst = 1'b1; out_en = 1'b0;
    tick();
    checks++;
    if (level !== 4'd0 || port_valid !== 1'b0) begin
      errors++; $display("FAIL reset_no_accept got level %0d valid %b want 0/0", level, port_valid);
    end
  endtask

  task automatic test_bypass();
    port_ready = 1'b1;
    out_en = 1'b1; addr_out = 3'd3; data_out = 32'h0000_00A5;
    tick();
    out_en = 1'b0;
    checks++;
    if (port_valid !== 1'b1 || port_addr !== 3'd3 || port_data !== 32'hA5) begin
      errors++; $display("FAIL bypass_head got v%b a%0d d%h want v1 a3 d000000a5", port_valid, port_addr, port_data);
    end
    checks++;
    if (level !== 4'd1) begin errors++; $display("FAIL bypass_level got %0d want 1", level); end
    tick();
    checks++;
    if (port_valid !== 1'b0 || level !== 4'd0) begin
      errors++; $display("FAIL bypass_drain got v%b level %0d want v0 level 0", port_valid, level);
    end
  endtask

  task automatic test_fill_overflow();
    port_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      out_en = 1'b1; addr_out = 3'(i); data_out = 32'(i);
      tick();
      checks++;
      if (level !== 4'((i > 5) ? 5 : i)) begin
        errors++; $display("FAIL fill_level_%0d got %0d want %0d", i, level, (i > 5) ? 5 : i);
      end
      checks++;
      if (ovf !== ((i == 6) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL fill_ovf_%0d got %b want %b", i, ovf, i == 6);
      end
    end
    out_en = 1'b0;
    port_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (port_valid !== 1'b1 || port_data !== 32'(k)) begin
        errors++; $display("FAIL drain_%0d got v%b d%0d want v1 d%0d", k, port_valid, port_data, k);
      end
      tick();
    end
    checks++;
    if (port_valid !== 1'b0 || level !== 4'd0) begin
      errors++; $display("FAIL drain_end got v%b level %0d want v0 level 0", port_valid, level);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", ovf); end
  endtask

  task automatic test_full_push_pop();
    port_ready = 1'b0;
    for (int i = 10; i <= 14; i++) begin
      out_en = 1'b1; addr_out = 3'd1; data_out = 32'(i);
      tick();
    end
    checks++;
    if (level !== 4'd5) begin errors++; $display("FAIL full_level got %0d want 5", level); end
    out_en = 1'b1; data_out = 32'd15; port_ready = 1'b1;
    tick();
    out_en = 1'b0;
    checks++;
    if (level !== 4'd5 || ovf !== 1'b0) begin
      errors++; $display("FAIL full_pushpop got level %0d ovf %b want 5/0", level, ovf);
    end
    for (int k = 11; k <= 15; k++) begin
      checks++;
      if (port_valid !== 1'b1 || port_data !== 32'(k)) begin
        errors++; $display("FAIL pushpop_drain_%0d got v%b d%0d want v1 d%0d", k, port_valid, port_data, k);
      end
      tick();
    end
    checks++;
    if (level !== 4'd0) begin errors++; $display("FAIL pushpop_end got %0d want 0", level); end
  endtask

  task automatic test_ovf_clr_race();
    port_ready = 1'b0;
    for (int i = 20; i <= 24; i++) begin
      out_en = 1'b1; addr_out = 3'd0; data_out = 32'(i);
      tick();
    end
    out_en = 1'b1; data_out = 32'd25; ovf_clr = 1'b1;
    tick();
    out_en = 1'b0;
    checks++;
    if (ovf !== 1'b1 || level !== 4'd5) begin
      errors++; $display("FAIL race_set_wins got ovf %b level %0d want 1/5", ovf, level);
    end
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL race_clear got %b want 0", ovf); end
    port_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (level !== 4'd0 || port_valid !== 1'b0) begin
      errors++; $display("FAIL race_drain got level %0d v%b want 0/0", level, port_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    port_ready = 1'b0;
    out_en = 1'b1; addr_out = 3'd2; data_out = 32'h1234;
    tick();
    out_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (port_valid !== 1'b1 || port_addr !== 3'd2 || port_data !== 32'h1234 || level !== 4'd1) begin
        errors++; $display("FAIL hold_%0d got v%b a%0d d%h l%0d want v1 a2 d00001234 l1",
                           c, port_valid, port_addr, port_data, level);
      end
      tick();
    end
    port_ready = 1'b1;
    tick();
    checks++;
    if (port_valid !== 1'b0) begin errors++; $display("FAIL hold_pop got v%b want 0", port_valid); end
`ifdef IO_OUT_SHADOW_EN
    begin
      logic [255:0] exp_shadow;
      exp_shadow = '0;
      exp_shadow[2*32 +: 32] = 32'h1234;
      checks++;
      if (shadow !== exp_shadow) begin
        errors++; $display("FAIL shadow got %h want %h", shadow, exp_shadow);
      end
    end
`endif
  endtask

  initial begin
    out_en = 1'b0; addr_out = '0; data_out = '0; port_ready = 1'b0; ovf_clr = 1'b0; rst = 1'b0;
    test_reset();
    test_bypass();
    test_fill_overflow();
    test_full_push_pop();
    test_ovf_clr_race();
    test_backpressure();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
